vga_plot_arbiter: RTL and testbench

VGA_PLOT_ARBITER -- requirements
Module: vga_plot_arbiter

---
 rtl/vga_plot_arbiter_if.sv | 40 ++++
 rtl/vga_plot_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_vga_plot_arbiter.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/vga_plot_arbiter_if.sv
// Plot-port bus between three drawing requesters and the arbiter.
// Compile-time option for the arbiter: VGA_ARB_WATCHDOG_EN.
// Signals:
//   req, done, pplot : per-requester request, end-of-drawing pulse, plot strobe (bit i = requester i)
//   px, py, pcolour  : per-requester pixel payload, requester i on slice i
//   gnt              : one-hot grant back to the requesters
//   x, y, colour     : registered pixel toward the vga_adapter
//   writeEn          : registered plot strobe toward the vga_adapter
//   busy, wd_fire    : ownership flag and watchdog revoke pulse
// Modports: master = requester side, slave = arbiter side.
interface vga_plot_arbiter_if;
    localparam int unsigned N_REQ = 3;
    localparam int unsigned X_W   = 8;
    localparam int unsigned Y_W   = 7;
    localparam int unsigned C_W   = 3;

    logic [N_REQ-1:0]     req;
    logic [N_REQ-1:0]     done;
    logic [N_REQ*X_W-1:0] px;
    logic [N_REQ*Y_W-1:0] py;
    logic [N_REQ*C_W-1:0] pcolour;
    logic [N_REQ-1:0]     pplot;
    logic [N_REQ-1:0]     gnt;
    logic [X_W-1:0]       x;
    logic [Y_W-1:0]       y;
    logic [C_W-1:0]       colour;
    logic                 writeEn;
    logic                 busy;
    logic                 wd_fire;

    modport master (
        output req, done, px, py, pcolour, pplot,
        input  gnt, x, y, colour, writeEn, busy, wd_fire
    );

    modport slave (
        input  req, done, px, py, pcolour, pplot,
        output gnt, x, y, colour, writeEn, busy, wd_fire
    );
endinterface

// File: rtl/vga_plot_arbiter.sv
// Round-robin arbiter sharing one vga_adapter plot port among three requesters.
// Optional feature macro: VGA_ARB_WATCHDOG_EN (revokes a grant held WD_LIMIT cycles).
// Ports:
//   fastclock : clock, all state updates on its rising edge
//   resetn    : asynchronous active-low reset
//   bus       : vga_plot_arbiter_if.slave (requests/payloads in, grant/pixel/status out)
// Parameters:
//   WD_LIMIT  : watchdog ownership limit in cycles (12-bit counter)
module vga_plot_arbiter #(
    parameter int unsigned WD_LIMIT = 4095
) (
    input  logic                 fastclock,
    input  logic                 resetn,
    vga_plot_arbiter_if.slave    bus
);
    localparam int unsigned N_REQ = 3;
    localparam int unsigned IDX_W = 2;
    localparam int unsigned X_W   = 8;
    localparam int unsigned Y_W   = 7;
    localparam int unsigned C_W   = 3;
    localparam int unsigned CNT_W = 12;

    // The owner counter is 12 bits wide, so the limit must fit in it.
    if (WD_LIMIT > 32'd4095) begin : g_wd_limit_chk
        $error("WD_LIMIT must fit the 12-bit owner counter");
    end

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_OWN     = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [X_W-1:0]     x_q, x_d;
    logic [Y_W-1:0]     y_q, y_d;
    logic [C_W-1:0]     colour_q, colour_d;
    logic               we_q, we_d;
    logic               busy_q, busy_d;
`ifdef VGA_ARB_WATCHDOG_EN
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               wd_fire_q, wd_fire_d;
`endif

    logic               win_valid;
    logic [IDX_W-1:0]   win_idx;
    logic [X_W-1:0]     own_x;
    logic [Y_W-1:0]     own_y;
    logic [C_W-1:0]     own_colour;
    logic               own_req;
    logic               own_done;
    logic               own_plot;
    logic               hand_back;

    // Round-robin pick: search last_owner+1, +2, +3 (mod 3); the nearest hit wins.
    always_comb begin
        int               pos;
        logic [IDX_W-1:0] cand;
        win_valid = 1'b0;
        win_idx   = '0;
        pos       = 0;
        cand      = '0;
        for (int k = 3; k >= 1; k--) begin
            pos  = (int'(last_q) + k) % 3;
            cand = IDX_W'(pos);
            if (bus.req[cand]) begin
                win_valid = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Owner's payload slice and control bits; everything from non-owners is ignored.
    always_comb begin
        case (owner_q)
            2'd0: begin
                own_x      = bus.px[7:0];
                own_y      = bus.py[6:0];
                own_colour = bus.pcolour[2:0];
            end
            2'd1: begin
                own_x      = bus.px[15:8];
                own_y      = bus.py[13:7];
                own_colour = bus.pcolour[5:3];
            end
            default: begin
                own_x      = bus.px[23:16];
                own_y      = bus.py[20:14];
                own_colour = bus.pcolour[8:6];
            end
        endcase
        own_req   = bus.req[owner_q];
        own_done  = bus.done[owner_q];
        own_plot  = bus.pplot[owner_q];
        hand_back = own_done || !own_req;
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        owner_d  = owner_q;
        last_d   = last_q;
        x_d      = x_q;
        y_d      = y_q;
        colour_d = colour_q;
        we_d     = 1'b0;
        busy_d   = 1'b0;
`ifdef VGA_ARB_WATCHDOG_EN
        cnt_d     = cnt_q;
        wd_fire_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (win_valid) begin
                    state_d = S_OWN;
                    gnt_d   = N_REQ'(3'b001 << win_idx);
                    owner_d = win_idx;
                    busy_d  = 1'b1;
`ifdef VGA_ARB_WATCHDOG_EN
                    cnt_d   = '0;
`endif
                end
            end
            S_OWN: begin
                busy_d = 1'b1;
                // The owner's plot is forwarded even in the cycle it hands back.
                we_d   = own_plot;
                if (own_plot) begin
                    x_d      = own_x;
                    y_d      = own_y;
                    colour_d = own_colour;
                end
                if (hand_back) begin
                    state_d = S_RELEASE;
                    busy_d  = 1'b0;
                end
`ifdef VGA_ARB_WATCHDOG_EN
                cnt_d = cnt_q + CNT_W'(1);
                // done/req-drop wins over the watchdog in the same cycle.
                if (!hand_back && (cnt_d == CNT_W'(WD_LIMIT))) begin
                    state_d   = S_RELEASE;
                    busy_d    = 1'b0;
                    wd_fire_d = 1'b1;
                end
`endif
            end
            S_RELEASE: begin
                // Grant drops here, leaving one dead IDLE cycle before the next grant.
                state_d = S_IDLE;
                gnt_d   = '0;
                last_d  = owner_q;
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge fastclock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            gnt_q     <= '0;
            owner_q   <= '0;
            last_q    <= IDX_W'(2);
            x_q       <= '0;
            y_q       <= '0;
            colour_q  <= '0;
            we_q      <= 1'b0;
            busy_q    <= 1'b0;
`ifdef VGA_ARB_WATCHDOG_EN
            cnt_q     <= '0;
            wd_fire_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            x_q       <= x_d;
            y_q       <= y_d;
            colour_q  <= colour_d;
            we_q      <= we_d;
            busy_q    <= busy_d;
`ifdef VGA_ARB_WATCHDOG_EN
            cnt_q     <= cnt_d;
            wd_fire_q <= wd_fire_d;
`endif
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.x       = x_q;
    assign bus.y       = y_q;
    assign bus.colour  = colour_q;
    assign bus.writeEn = we_q;
    assign bus.busy    = busy_q;
`ifdef VGA_ARB_WATCHDOG_EN
    assign bus.wd_fire = wd_fire_q;
`else
    assign bus.wd_fire = 1'b0;
`endif

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Self-checking bench for vga_plot_arbiter: directed vector table plus
// hand-written reset and ownership-limit sequences.
module tb_vga_plot_arbiter;
    logic fastclock;
    logic resetn;
    int   n_cmp;
    int   n_fail;

    vga_plot_arbiter_if bus ();

    vga_plot_arbiter #(.WD_LIMIT(8)) dut (
        .fastclock (fastclock),
        .resetn    (resetn),
        .bus       (bus)
    );

    initial fastclock = 1'b0;
    always #5 fastclock = ~fastclock;

    typedef struct {
        logic [2:0]  req;
        logic [2:0]  done;
        logic [2:0]  pplot;
        logic [23:0] px;
        logic [20:0] py;
        logic [8:0]  pcolour;
        logic [2:0]  e_gnt;
        logic [7:0]  e_x;
        logic [6:0]  e_y;
        logic [2:0]  e_col;
        logic        e_we;
        logic        e_busy;
    } vec_t;

    vec_t vecs [20];

    function automatic vec_t mk(input logic [2:0] req, input logic [2:0] done,
                                input logic [2:0] pplot, input logic [23:0] px,
                                input logic [20:0] py, input logic [8:0] pc,
                                input logic [2:0] gnt, input logic [7:0] x,
                                input logic [6:0] y, input logic [2:0] col,
                                input logic we, input logic busy);
        vec_t v;
        v.req = req; v.done = done; v.pplot = pplot;
        v.px = px; v.py = py; v.pcolour = pc;
        v.e_gnt = gnt; v.e_x = x; v.e_y = y; v.e_col = col;
        v.e_we = we; v.e_busy = busy;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [2:0] req, input logic [2:0] done, input logic [2:0] pplot,
                         input logic [23:0] px, input logic [20:0] py, input logic [8:0] pc);
        bus.req = req; bus.done = done; bus.pplot = pplot;
        bus.px = px; bus.py = py; bus.pcolour = pc;
    endtask

    task automatic step();
        @(posedge fastclock);
        @(negedge fastclock);
    endtask

    initial begin
        int cycles;
        bit seen;
        n_cmp  = 0;
        n_fail = 0;

        //          req     done    pplot   px                         py                        pcolour                | gnt     x      y      col  we busy
        vecs[0]  = mk(3'b111, 3'b000, 3'b000, 24'd0,                     21'd0,                    9'd0,                    3'b001, 8'd0,  7'd0,  3'd0, 0, 1);
        vecs[1]  = mk(3'b111, 3'b000, 3'b001, {16'd0, 8'd5},             {14'd0, 7'd3},            {6'd0, 3'd7},            3'b001, 8'd5,  7'd3,  3'd7, 1, 1);
        vecs[2]  = mk(3'b111, 3'b000, 3'b110, {8'd77, 8'd66, 8'd9},      {7'd1, 7'd2, 7'd4},       {3'd1, 3'd2, 3'd3},      3'b001, 8'd5,  7'd3,  3'd7, 0, 1);
        vecs[3]  = mk(3'b111, 3'b001, 3'b001, {16'd0, 8'd11},            {14'd0, 7'd4},            {6'd0, 3'd2},            3'b001, 8'd11, 7'd4,  3'd2, 1, 0);
        vecs[4]  = mk(3'b111, 3'b000, 3'b000, 24'd0,                     21'd0,                    9'd0,                    3'b000, 8'd11, 7'd4,  3'd2, 0, 0);
        vecs[5]  = mk(3'b111, 3'b000, 3'b000, 24'd0,                     21'd0,                    9'd0,                    3'b010, 8'd11, 7'd4,  3'd2, 0, 1);
        vecs[6]  = mk(3'b111, 3'b000, 3'b010, {8'd1, 8'd42, 8'd99},      {7'd5, 7'd17, 7'd6},      {3'd1, 3'b110, 3'd3},    3'b010, 8'd42, 7'd17, 3'd6, 1, 1);
        vecs[7]  = mk(3'b111, 3'b010, 3'b000, 24'd0,                     21'd0,                    9'd0,                    3'b010, 8'd42, 7'd17, 3'd6, 0, 0);
        vecs[8]  = mk(3'b111, 3'b000, 3'b000, 24'd0,                     21'd0,                    9'd0,                    3'b000, 8'd42, 7'd17, 3'd6, 0, 0);
        vecs[9]  = mk(3'b111, 3'b000, 3'b000, 24'd0,                     21'd0,                    9'd0,                    3'b100, 8'd42, 7'd17, 3'd6, 0, 1);
        vecs[10] = mk(3'b011, 3'b000, 3'b100, {8'd200, 16'd0},           {7'd99, 14'd0},           {3'd5, 6'd0},            3'b100, 8'd200, 7'd99, 3'd5, 1, 0);
        vecs[11] = mk(3'b011, 3'b000, 3'b000, 24'd0,                     21'd0,                    9'd0,                    3'b000, 8'd200, 7'd99, 3'd5, 0, 0);
        vecs[12] = mk(3'b011, 3'b000, 3'b000, 24'd0,                     21'd0,                    9'd0,                    3'b001, 8'd200, 7'd99, 3'd5, 0, 1);
        vecs[13] = mk(3'b011, 3'b010, 3'b010, {8'd0, 8'd33, 8'd0},       {7'd0, 7'd33, 7'd0},      {3'd0, 3'd7, 3'd0},      3'b001, 8'd200, 7'd99, 3'd5, 0, 1);
        vecs[14] = mk(3'b000, 3'b000, 3'b000, 24'd0,                     21'd0,                    9'd0,                    3'b001, 8'd200, 7'd99, 3'd5, 0, 0);
        vecs[15] = mk(3'b000, 3'b000, 3'b000, 24'd0,                     21'd0,                    9'd0,                    3'b000, 8'd200, 7'd99, 3'd5, 0, 0);
        vecs[16] = mk(3'b000, 3'b000, 3'b000, 24'd0,                     21'd0,                    9'd0,                    3'b000, 8'd200, 7'd99, 3'd5, 0, 0);
        vecs[17] = mk(3'b100, 3'b000, 3'b000, 24'd0,                     21'd0,                    9'd0,                    3'b100, 8'd200, 7'd99, 3'd5, 0, 1);
        vecs[18] = mk(3'b000, 3'b000, 3'b000, 24'd0,                     21'd0,                    9'd0,                    3'b100, 8'd200, 7'd99, 3'd5, 0, 0);
        vecs[19] = mk(3'b000, 3'b000, 3'b000, 24'd0,                     21'd0,                    9'd0,                    3'b000, 8'd200, 7'd99, 3'd5, 0, 0);

        // Reset state
        resetn = 1'b0;
        drive(3'b000, 3'b000, 3'b000, 24'd0, 21'd0, 9'd0);
        #12;
        check("rst_gnt",     32'(bus.gnt),     32'd0);
        check("rst_x",       32'(bus.x),       32'd0);
        check("rst_y",       32'(bus.y),       32'd0);
        check("rst_colour",  32'(bus.colour),  32'd0);
        check("rst_writeEn", 32'(bus.writeEn), 32'd0);
        check("rst_busy",    32'(bus.busy),    32'd0);
        check("rst_wd_fire", 32'(bus.wd_fire), 32'd0);
        @(negedge fastclock);
        resetn = 1'b1;

        // Directed vector table
        for (int i = 0; i < 20; i++) begin
            drive(vecs[i].req, vecs[i].done, vecs[i].pplot, vecs[i].px, vecs[i].py, vecs[i].pcolour);
            step();
            check($sformatf("v%0d_gnt", i),     32'(bus.gnt),     32'(vecs[i].e_gnt));
            check($sformatf("v%0d_x", i),       32'(bus.x),       32'(vecs[i].e_x));
            check($sformatf("v%0d_y", i),       32'(bus.y),       32'(vecs[i].e_y));
            check($sformatf("v%0d_colour", i),  32'(bus.colour),  32'(vecs[i].e_col));
            check($sformatf("v%0d_writeEn", i), 32'(bus.writeEn), 32'(vecs[i].e_we));
            check($sformatf("v%0d_busy", i),    32'(bus.busy),    32'(vecs[i].e_busy));
            check($sformatf("v%0d_onehot", i),  32'($countones(bus.gnt) <= 1), 32'd1);
        end

        // Reset mid-ownership while the owner plots every cycle
        drive(3'b001, 3'b000, 3'b001, {16'd0, 8'd50}, {14'd0, 7'd10}, {6'd0, 3'd4});
        step();
        check("mr_gnt", 32'(bus.gnt), 32'b001);
        step();
        check("mr_writeEn", 32'(bus.writeEn), 32'd1);
        check("mr_x",       32'(bus.x),       32'd50);
        @(posedge fastclock);
        #2;
        resetn = 1'b0;
        #1;
        check("mr_async_gnt",     32'(bus.gnt),     32'd0);
        check("mr_async_writeEn", 32'(bus.writeEn), 32'd0);
        check("mr_async_busy",    32'(bus.busy),    32'd0);
        check("mr_async_x",       32'(bus.x),       32'd0);
        @(negedge fastclock);
        check("mr_held_writeEn", 32'(bus.writeEn), 32'd0);
        drive(3'b011, 3'b000, 3'b000, 24'd0, 21'd0, 9'd0);
        resetn = 1'b1;
        step();
        check("mr_first_gnt", 32'(bus.gnt), 32'b001);

        // Owner 0 holds the port with no done: watchdog revoke or unbounded ownership
        drive(3'b001, 3'b000, 3'b000, 24'd0, 21'd0, 9'd0);
        cycles = 0;
        seen   = 1'b0;
`ifdef VGA_ARB_WATCHDOG_EN
        while (!seen && cycles < 20) begin
            step();
            cycles++;
            if (bus.wd_fire) seen = 1'b1;
        end
        check("wd_fired",       32'(seen),        32'd1);
        check("wd_fire_cycle",  32'(cycles),      32'd8);
        check("wd_busy",        32'(bus.busy),    32'd0);
        step();
        check("wd_pulse_width", 32'(bus.wd_fire), 32'd0);
        check("wd_gnt_cleared", 32'(bus.gnt),     32'b000);
`else
        while (cycles < 20) begin
            step();
            cycles++;
            if (bus.wd_fire || bus.gnt != 3'b001) seen = 1'b1;
        end
        check("own_unbounded", 32'(seen),     32'd0);
        check("own_busy",      32'(bus.busy), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
